tape_load_ctrl: RTL and testbench
=================================

Name: tape_load_ctrl

Overview:
- Sequencer for fast tape loading on ZX80/ZX81.
- Captures length of a tape image downloaded into the tape buffer; waits for the CPU to enter the ROM LOAD routine; substitutes a 7-byte wait-loop patch for the ROM.
- Streams buffer bytes into SDRAM at one byte per CPU clock enable, then releases the loop so the CPU resumes at the ROM post-load entry.
- Sits between the ioctl download path, the tape buffer RAM, the SDRAM write port and the CPU memory read mux.

Parameters:
- ADDR_W, 14, tape buffer address width (16 KB buffer).
- ZX81_ENTRY, 16'h0347, ZX81 LOAD entry fetch address.
- ZX81_EXIT, 16'h03C3, ZX81 first address past the patched window.
- ZX80_ENTRY, 16'h0207, ZX80 LOAD entry fetch address.
- ZX80_EXIT, 16'h024D, ZX80 first address past the patched window.

Ports:
- clk_sys  in  1  system clock (52 MHz).
- reset  in  1  synchronous, active-high.
- ce_cpu_p  in  1  CPU positive clock enable; paces copying.
- zx81  in  1  1 = ZX81 addresses and patch, 0 = ZX80.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download type; 0 = ROM (ignored); [7:6]==1 = .p file, else .o file.
- ioctl_wr  in  1  download byte strobe.
- ioctl_addr  in  ADDR_W  download byte address.
- nM1  in  1  CPU M1, active low.
- addr  in  16  CPU address bus.
- tape_rd_addr  out  ADDR_W  tape buffer read address; buffer returns data 1 clk later.
- tape_byte  in  8  tape buffer read data.
- ram_we  out  1  one-clk SDRAM write strobe.
- ram_wr_addr  out  16  SDRAM write address.
- ram_wr_data  out  8  SDRAM write data.
- active  out  1  patch window active; CPU ROM reads must use patch_dout; ram address mux selects ram_wr_addr.
- patch_idx  in  3  addr minus current entry address.
- patch_dout  out  8  patch byte, combinational.
- tape_ready  out  1  valid image held in the buffer.

Behaviour:
- Clocking: single clock clk_sys. Reset is synchronous and active-high. Reset values: state IDLE; tape_ready 0; active 0; ram_we 0; count 0; len 0; ram_wr_addr 0; ram_wr_data 0. Reset mid-load aborts immediately; no further writes are issued.
- Length capture: on ioctl_wr with ioctl_index != 0, len <= max(len, ioctl_addr+1). len clears on a rising ioctl_download with index != 0.
- On a falling ioctl_download with index != 0:
  - tape_ready <= (len != 0).
  - pfile <= (ioctl_index[7:6] == 1).
- States:
  - IDLE: tape_ready=0. Goes to ARMED when tape_ready is set.
  - ARMED: on an M1 falling edge (nM1 registered) with addr == entry for the current zx81 setting, count <= 0 and go to LOADING. active=1 from the next clk.
  - LOADING: on each ce_cpu_p with count != len:
    - ram_we <= 1 for exactly one clk.
    - ram_wr_data <= tape_byte, which was addressed by count at least 1 clk earlier.
    - ram_wr_addr <= count + (pfile ? 16'h4009 : 16'h4000).
    - count <= count + 1.
    - When count == len, go to DONE.
  - DONE: no writes. Exit to ARMED on an M1 falling edge with addr >= exit or addr < entry.
  - Exit rule in LOADING: the same exit condition goes to ARMED and abandons the load.
- tape_rd_addr = count at all times.
- Patch bytes, index 0..6: AF, P1, 30, FD, C3, LO, 02.
  - P1 = 00 in LOADING, 37 in DONE.
  - LO = 07 when zx81, 03 when ZX80.
  - Index 7 returns 00.
- Download rise (index != 0) in any state: go to IDLE, active 0, tape_ready 0.
- ROM download (index 0): no effect.
- Entry fetch while already LOADING or DONE: ignored.
- ce_cpu_p coinciding with an exit: the exit wins and no write is issued.
- count never exceeds len; a 16 KB image (len = 16384) requires count width ADDR_W+1.

Decomposition:
- Shared package zx8x_pkg holds:
  - state enum tape_state_t {IDLE, ARMED, LOADING, DONE};
  - entry and exit address constants;
  - patch opcode constants (XOR_A=AF, NOP=00, SCF=37, JR_NC=30, JP=C3).
- One sub-module tape_patch_rom: combinational 7-byte table taking patch_idx, loading flag and zx81.

Test Plan:
- Download .o of 3 bytes {11,22,33}, index 1, zx81=1; M1 at 0347 -> writes 4000=11, 4001=22, 4002=33 on three successive ce_cpu_p; patch_dout[1] goes 00 then 37.
- .p download (index 8'h40), 2 bytes, zx81=0; M1 at 0207 -> writes to 4009 and 400A; patch_dout[5] = 03.
- M1 at 0300 during LOADING with 100-byte image -> ARMED, active 0, no further ram_we; a later M1 at 0347 restarts at count 0.
- reset asserted mid-load -> next clk: ram_we 0, tape_ready 0, active 0; a following M1 at 0347 produces no activity.
- New download rising during DONE -> IDLE, tape_ready 0; a download with no ioctl_wr leaves tape_ready 0.
- ROM download (index 0) while ARMED -> state and len unchanged; M1 at 0347 still triggers loading.

Source files
------------

// File: rtl/zx8x_pkg.sv
// Shared ZX80/ZX81 tape-loader definitions: FSM states, ROM LOAD window addresses,
// Z80 opcodes used by the wait-loop patch and SDRAM load base addresses.
package zx8x_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, LOADING, DONE} tape_state_t;

  localparam logic [15:0] ZX81_ENTRY_ADDR = 16'h0347;
  localparam logic [15:0] ZX81_EXIT_ADDR  = 16'h03C3;
  localparam logic [15:0] ZX80_ENTRY_ADDR = 16'h0207;
  localparam logic [15:0] ZX80_EXIT_ADDR  = 16'h024D;

  localparam logic [7:0] XOR_A   = 8'hAF;
  localparam logic [7:0] NOP     = 8'h00;
  localparam logic [7:0] SCF     = 8'h37;
  localparam logic [7:0] JR_NC   = 8'h30;
  localparam logic [7:0] JP      = 8'hC3;
  localparam logic [7:0] JR_BACK = 8'hFD;

  // .o images load at the start of RAM, .p images skip the system variables.
  localparam logic [15:0] O_BASE = 16'h4000;
  localparam logic [15:0] P_BASE = 16'h4009;

endpackage

// File: rtl/tape_load_ctrl_if.sv
// Download-in / SDRAM-write-out bus of the tape loader; master is the ioctl and
// SDRAM side, slave is the loader.
interface tape_load_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic              ram_we;
  logic [15:0]       ram_wr_addr;
  logic [7:0]        ram_wr_data;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr,
    input  ram_we, ram_wr_addr, ram_wr_data
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr,
    output ram_we, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/tape_load_ctrl_patch_rom.sv
// Seven-byte ROM patch: XOR A / JR NC,-3 spins until DONE swaps NOP for SCF,
// then JP to the post-load entry. Purely combinational.
module tape_patch_rom
  import zx8x_pkg::*;
(
  input  logic [2:0] patch_idx,
  input  logic       loading,
  input  logic       zx81,
  output logic [7:0] patch_dout
);

  always_comb begin
    patch_dout = NOP;
    case (patch_idx)
      3'd0:    patch_dout = XOR_A;
      3'd1:    patch_dout = loading ? NOP : SCF;
      3'd2:    patch_dout = JR_NC;
      3'd3:    patch_dout = JR_BACK;
      3'd4:    patch_dout = JP;
      3'd5:    patch_dout = zx81 ? 8'h07 : 8'h03;
      3'd6:    patch_dout = 8'h02;
      default: patch_dout = NOP;
    endcase
  end

endmodule

// File: rtl/tape_load_ctrl.sv
// Fast tape loader: copies the buffered image to SDRAM while the CPU spins in a patched
// LOAD loop; one byte per ce_cpu_p, write strobe one clk after the enable, no stall input.
module tape_load_ctrl
  import zx8x_pkg::*;
#(
  parameter int          ADDR_W     = 14,
  parameter logic [15:0] ZX81_ENTRY = ZX81_ENTRY_ADDR,
  parameter logic [15:0] ZX81_EXIT  = ZX81_EXIT_ADDR,
  parameter logic [15:0] ZX80_ENTRY = ZX80_ENTRY_ADDR,
  parameter logic [15:0] ZX80_EXIT  = ZX80_EXIT_ADDR
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_cpu_p,
  input  logic              zx81,
  tape_load_ctrl_if.slave   bus,
  input  logic              nM1,
  input  logic [15:0]       addr,
  output logic [ADDR_W-1:0] tape_rd_addr,
  input  logic [7:0]        tape_byte,
  output logic              active,
  input  logic [2:0]        patch_idx,
  output logic [7:0]        patch_dout,
  output logic              tape_ready
);

  // One extra bit so a completely full buffer (len == 2**ADDR_W) is representable.
  localparam int LEN_W = ADDR_W + 1;

  tape_state_t      state, state_nxt;
  logic [LEN_W-1:0] len, count, wr_len;
  logic             dl_q, nm1_q, pfile;
  logic             tape_dl, dl_rise, dl_fall, m1_fall;
  logic [15:0]      entry_a, exit_a;
  logic             outside, do_start, do_write;

  assign tape_dl = (bus.ioctl_index != 8'd0);
  assign dl_rise = bus.ioctl_download & ~dl_q & tape_dl;
  assign dl_fall = ~bus.ioctl_download & dl_q & tape_dl;
  assign m1_fall = nm1_q & ~nM1;
  assign entry_a = zx81 ? ZX81_ENTRY : ZX80_ENTRY;
  assign exit_a  = zx81 ? ZX81_EXIT : ZX80_EXIT;
  assign outside = (addr >= exit_a) || (addr < entry_a);
  assign wr_len  = {1'b0, bus.ioctl_addr} + LEN_W'(1);

  assign tape_rd_addr = count[ADDR_W-1:0];
  assign active       = (state == LOADING) || (state == DONE);

  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_write  = 1'b0;
    unique case (state)
      IDLE:    if (tape_ready) state_nxt = ARMED;
      ARMED: begin
        if (m1_fall && (addr == entry_a)) begin
          state_nxt = LOADING;
          do_start  = 1'b1;
        end
      end
      // Leaving the window beats both completion and a coincident enable.
      LOADING: begin
        if (m1_fall && outside)  state_nxt = ARMED;
        else if (count == len)   state_nxt = DONE;
        else if (ce_cpu_p)       do_write  = 1'b1;
      end
      DONE:    if (m1_fall && outside) state_nxt = ARMED;
    endcase
    if (dl_rise) begin
      state_nxt = IDLE;
      do_start  = 1'b0;
      do_write  = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q            <= 1'b0;
      nm1_q           <= 1'b1;
      len             <= '0;
      count           <= '0;
      pfile           <= 1'b0;
      tape_ready      <= 1'b0;
      bus.ram_we      <= 1'b0;
      bus.ram_wr_addr <= '0;
      bus.ram_wr_data <= '0;
    end else begin
      dl_q       <= bus.ioctl_download;
      nm1_q      <= nM1;
      bus.ram_we <= do_write;
      if (dl_rise) begin
        len        <= '0;
        tape_ready <= 1'b0;
      end else if (bus.ioctl_wr && tape_dl && (wr_len > len)) begin
        len <= wr_len;
      end
      if (dl_fall) begin
        tape_ready <= (len != '0);
        pfile      <= (bus.ioctl_index[7:6] == 2'd1);
      end
      if (do_start) count <= '0;
      if (do_write) begin
        count           <= count + LEN_W'(1);
        bus.ram_wr_data <= tape_byte;
        bus.ram_wr_addr <= 16'(count) + (pfile ? P_BASE : O_BASE);
      end
    end
  end

  tape_patch_rom u_patch (
    .patch_idx  (patch_idx),
    .loading    (state == LOADING),
    .zx81       (zx81),
    .patch_dout (patch_dout)
  );

endmodule

// File: tb/tb_tape_load_ctrl.sv
// Bench for tape_load_ctrl: patch table vectors, directed load/abort/reset sequences,
// randomized loads against a byte-list reference model, and a full 16 KB image.
module tb_tape_load_ctrl;
  import zx8x_pkg::*;

  localparam int AW = 14;

  logic          clk_sys, reset, ce_cpu_p, zx81, nM1, active, tape_ready;
  logic [15:0]   addr;
  logic [AW-1:0] tape_rd_addr;
  logic [7:0]    tape_byte, patch_dout;
  logic [2:0]    patch_idx;

  tape_load_ctrl_if #(.ADDR_W(AW)) bus ();

  tape_load_ctrl #(.ADDR_W(AW)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ce_cpu_p     (ce_cpu_p),
    .zx81         (zx81),
    .bus          (bus),
    .nM1          (nM1),
    .addr         (addr),
    .tape_rd_addr (tape_rd_addr),
    .tape_byte    (tape_byte),
    .active       (active),
    .patch_idx    (patch_idx),
    .patch_dout   (patch_dout),
    .tape_ready   (tape_ready)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  logic [7:0]  buf_mem [0:16383];
  logic [23:0] wr_q[$];
  logic [23:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk_sys) tape_byte <= buf_mem[tape_rd_addr];
  always @(negedge clk_sys) if (bus.ram_we === 1'b1) wr_q.push_back({bus.ram_wr_addr, bus.ram_wr_data});

  typedef struct {
    logic       in_load;
    logic       z81;
    logic [2:0] idx;
    logic [7:0] exp;
  } pvec_t;
  localparam int NP = 13;
  pvec_t ptab [NP];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_writes(input string name);
    int bad;
    bad = 0;
    chk({name, "_count"}, wr_q.size(), exp_q.size());
    if (wr_q.size() == exp_q.size()) begin
      for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== exp_q[i]) bad++;
      chk({name, "_data"}, bad, 0);
    end
    wr_q.delete();
    exp_q.delete();
  endtask

  // Bytes come from buf_mem[0..n-1]; the buffer image itself is set by the caller.
  task automatic download(input logic [7:0] idx, input int n);
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = idx;
    tick();
    for (int i = 0; i < n; i++) begin
      bus.ioctl_addr = AW'(i);
      bus.ioctl_wr   = 1'b1;
      tick();
      bus.ioctl_wr = 1'b0;
      tick();
    end
    bus.ioctl_download = 1'b0;
    tick();
    tick();
  endtask

  task automatic m1(input logic [15:0] a);
    addr = a;
    nM1  = 1'b0;
    tick();
    nM1 = 1'b1;
    tick();
  endtask

  task automatic ce_pulse();
    ce_cpu_p = 1'b1;
    tick();
    ce_cpu_p = 1'b0;
    tick();
  endtask

  task automatic expect_range(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) exp_q.push_back({16'(base + 16'(i)), buf_mem[i]});
  endtask

  task automatic apply_ptab(input logic phase);
    logic z_save;
    z_save = zx81;
    for (int i = 0; i < NP; i++) begin
      if (ptab[i].in_load == phase) begin
        zx81      = ptab[i].z81;
        patch_idx = ptab[i].idx;
        #2;
        chk($sformatf("patch_vec_%0d", i), patch_dout, ptab[i].exp);
        tick();
      end
    end
    zx81 = z_save;
  endtask

  task automatic patch1(input string name, input logic [7:0] exp);
    patch_idx = 3'd1;
    #2;
    chk(name, patch_dout, exp);
    tick();
  endtask

  int          len_r, k_r, nwr;
  logic        pf_r, z_r, abort_r;
  logic [7:0]  idx_r;
  logic [15:0] ent_r, ext_r;

  initial begin
    ptab[0]  = '{1'b1, 1'b1, 3'd0, 8'hAF};
    ptab[1]  = '{1'b1, 1'b1, 3'd1, 8'h00};
    ptab[2]  = '{1'b1, 1'b1, 3'd2, 8'h30};
    ptab[3]  = '{1'b1, 1'b1, 3'd3, 8'hFD};
    ptab[4]  = '{1'b1, 1'b1, 3'd4, 8'hC3};
    ptab[5]  = '{1'b1, 1'b1, 3'd5, 8'h07};
    ptab[6]  = '{1'b1, 1'b0, 3'd5, 8'h03};
    ptab[7]  = '{1'b1, 1'b1, 3'd6, 8'h02};
    ptab[8]  = '{1'b1, 1'b1, 3'd7, 8'h00};
    ptab[9]  = '{1'b0, 1'b1, 3'd1, 8'h37};
    ptab[10] = '{1'b0, 1'b0, 3'd5, 8'h03};
    ptab[11] = '{1'b0, 1'b1, 3'd5, 8'h07};
    ptab[12] = '{1'b0, 1'b0, 3'd0, 8'hAF};

    for (int i = 0; i < 16384; i++) buf_mem[i] = 8'h00;
    reset = 1'b1; ce_cpu_p = 1'b0; zx81 = 1'b1; nM1 = 1'b1; addr = '0; patch_idx = '0;
    bus.ioctl_download = 1'b0; bus.ioctl_index = '0; bus.ioctl_wr = 1'b0; bus.ioctl_addr = '0;
    tick();
    tick();
    chk("rst_tape_ready", tape_ready, 0);
    chk("rst_active", active, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_wr_addr", bus.ram_wr_addr, 0);
    chk("rst_wr_data", bus.ram_wr_data, 0);
    chk("rst_rd_addr", tape_rd_addr, 0);
    reset = 1'b0;
    tick();

    // Three-byte .o on ZX81
    buf_mem[0] = 8'h11; buf_mem[1] = 8'h22; buf_mem[2] = 8'h33;
    download(8'h01, 3);
    chk("o_tape_ready", tape_ready, 1);
    chk("o_armed_inactive", active, 0);
    m1(16'h0347);
    chk("o_active", active, 1);
    apply_ptab(1'b1);
    for (int i = 0; i < 3; i++) ce_pulse();
    exp_q = '{24'h400011, 24'h400122, 24'h400233};
    check_writes("o_writes");
    apply_ptab(1'b0);

    // Two-byte .p on ZX80
    zx81 = 1'b0;
    buf_mem[0] = 8'hA5; buf_mem[1] = 8'h5A;
    download(8'h40, 2);
    m1(16'h0207);
    chk("p_active", active, 1);
    patch_idx = 3'd5;
    #2;
    chk("p_patch5", patch_dout, 8'h03);
    tick();
    ce_pulse();
    ce_pulse();
    exp_q = '{24'h4009A5, 24'h400A5A};
    check_writes("p_writes");
    patch1("p_done_p1", 8'h37);

    // New download while DONE, then an empty one
    zx81 = 1'b1;
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'h01;
    tick();
    chk("redl_tape_ready", tape_ready, 0);
    chk("redl_active", active, 0);
    bus.ioctl_download = 1'b0;
    tick();
    tick();
    chk("empty_tape_ready", tape_ready, 0);
    m1(16'h0347);
    chk("empty_no_load", active, 0);

    // ROM download while ARMED is ignored
    buf_mem[0] = 8'h01; buf_mem[1] = 8'h02;
    download(8'h81, 2);
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'h00;
    tick();
    bus.ioctl_addr = AW'(500);
    bus.ioctl_wr   = 1'b1;
    tick();
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    tick();
    tick();
    chk("rom_tape_ready", tape_ready, 1);
    m1(16'h0347);
    chk("rom_active", active, 1);
    for (int i = 0; i < 3; i++) ce_pulse();
    expect_range(2, 16'h4000);
    check_writes("rom_writes");
    patch1("rom_done_p1", 8'h37);

    // Abort a 100-byte load by fetching below the window, then restart
    for (int i = 0; i < 100; i++) buf_mem[i] = 8'($urandom);
    download(8'h02, 100);
    m1(16'h0347);
    for (int i = 0; i < 5; i++) ce_pulse();
    m1(16'h0300);
    chk("abort_active", active, 0);
    for (int i = 0; i < 3; i++) ce_pulse();
    expect_range(5, 16'h4000);
    check_writes("abort_writes");
    m1(16'h0347);
    chk("restart_active", active, 1);
    ce_pulse();
    expect_range(1, 16'h4000);
    check_writes("restart_writes");

    // Exit fetch coinciding with a CPU enable
    addr     = 16'h0400;
    nM1      = 1'b0;
    ce_cpu_p = 1'b1;
    tick();
    nM1      = 1'b1;
    ce_cpu_p = 1'b0;
    tick();
    chk("exit_ce_active", active, 0);
    check_writes("exit_ce_writes");

    // Reset in the middle of a load, coinciding with an enable
    m1(16'h0347);
    ce_pulse();
    reset    = 1'b1;
    ce_cpu_p = 1'b1;
    tick();
    chk("midrst_ram_we", bus.ram_we, 0);
    chk("midrst_tape_ready", tape_ready, 0);
    chk("midrst_active", active, 0);
    reset    = 1'b0;
    ce_cpu_p = 1'b0;
    tick();
    m1(16'h0347);
    ce_pulse();
    ce_pulse();
    chk("postrst_active", active, 0);
    expect_range(1, 16'h4000);
    check_writes("midrst_writes");

    // Randomized loads: expected writes are the first min(K, L) bytes of the image
    for (int t = 0; t < 20; t++) begin
      len_r = $urandom_range(1, 40);
      pf_r  = 1'($urandom_range(0, 1));
      z_r   = 1'($urandom_range(0, 1));
      idx_r = pf_r ? 8'(8'h40 + $urandom_range(0, 63))
                   : 8'(($urandom_range(0, 1) ? 8'h80 : 8'h00) + $urandom_range(1, 63));
      ent_r = z_r ? 16'h0347 : 16'h0207;
      ext_r = z_r ? 16'h03C3 : 16'h024D;
      zx81  = z_r;
      for (int i = 0; i < len_r; i++) buf_mem[i] = 8'($urandom);
      download(idx_r, len_r);
      chk($sformatf("rnd%0d_ready", t), tape_ready, 1);
      m1(ent_r);
      k_r     = $urandom_range(0, len_r + 2);
      abort_r = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < k_r; i++) begin
        if ($urandom_range(0, 3) == 0) m1(16'(ent_r + 16'($urandom_range(0, int'(ext_r - ent_r) - 1))));
        ce_pulse();
      end
      if (abort_r)
        m1($urandom_range(0, 1) ? 16'(ent_r - 16'd1 - 16'($urandom_range(0, 511)))
                                : 16'(ext_r + 16'($urandom_range(0, 12288))));
      nwr = (k_r < len_r) ? k_r : len_r;
      expect_range(nwr, pf_r ? 16'h4009 : 16'h4000);
      check_writes($sformatf("rnd%0d", t));
      chk($sformatf("rnd%0d_active", t), active, !abort_r);
      if (!abort_r) patch1($sformatf("rnd%0d_p1", t), (k_r >= len_r) ? 8'h37 : 8'h00);
    end

    // Full 16 KB image: a single write at the last address sets len to 16384
    zx81 = 1'b1;
    for (int i = 0; i < 16384; i++) buf_mem[i] = 8'($urandom);
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = 8'h01;
    tick();
    bus.ioctl_addr = AW'(16383);
    bus.ioctl_wr   = 1'b1;
    tick();
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    tick();
    tick();
    chk("full_ready", tape_ready, 1);
    m1(16'h0347);
    for (int i = 0; i < 16385; i++) ce_pulse();
    expect_range(16384, 16'h4000);
    check_writes("full_writes");
    chk("full_active", active, 1);
    patch1("full_done_p1", 8'h37);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
